// File: rtl/vending_pkg.sv
// vending_pkg
//   Shared types and constants for the vending machine controller.
//   - state_e      : controller FSM states
//   - COIN_*       : coin values in 5-cent units
//   - PRICE_DEF    : default item price in 5-cent units
//   - SUM_W_DEF    : default credit / change width (matches sum_register)
//   - coin_t       : decoded coin information handed from the decoder to the FSM
package vending_pkg;

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_DISPENSE = 2'd1,
    S_CHANGE   = 2'd2
  } state_e;

  localparam logic [2:0] COIN_NICKEL  = 3'd1;
  localparam logic [2:0] COIN_DIME    = 3'd2;
  localparam logic [2:0] COIN_QUARTER = 3'd5;

  localparam int PRICE_DEF = 4;
  localparam int SUM_W_DEF = 3;

  typedef struct packed {
    logic       valid;  // exactly one coin bit set
    logic       multi;  // more than one coin bit set
    logic [2:0] value;  // coin value, 0 unless valid
  } coin_t;

endpackage

// File: rtl/vending_coin_decode.sv
// vending_coin_decode
//   Combinational coin decoder. Turns the three single-cycle coin pulses into
//   a coin value plus valid / multi-coin flags.
//   Ports:
//     i_nickel, i_dime, i_quarter : coin pulses from the acceptor
//     o_valid                     : exactly one coin present
//     o_multi                     : two or more coins in the same cycle
//     o_value                     : value of the single coin (0 when !o_valid)
module vending_coin_decode
  import vending_pkg::*;
(
  input  logic       i_nickel,
  input  logic       i_dime,
  input  logic       i_quarter,
  output logic       o_valid,
  output logic       o_multi,
  output logic [2:0] o_value
);

  logic [1:0] n_coins;
  coin_t      coin;

  always_comb begin
    n_coins    = {1'b0, i_nickel} + {1'b0, i_dime} + {1'b0, i_quarter};
    coin       = '0;
    coin.valid = (n_coins == 2'd1);
    coin.multi = (n_coins > 2'd1);
    if (coin.valid) begin
      if (i_nickel)    coin.value = COIN_NICKEL;
      else if (i_dime) coin.value = COIN_DIME;
      else             coin.value = COIN_QUARTER;
    end
  end

  assign o_valid = coin.valid;
  assign o_multi = coin.multi;
  assign o_value = coin.value;

endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl
//   Vending machine controller. Sequences the external credit register
//   (sum_register): accumulates coins into it, dispenses when the price is
//   reached, clears it, and hands change out over a valid/ack handshake.
//   Ports:
//     i_clk, i_rst          : clock (rising edge), async active-high reset
//     i_nickel/dime/quarter : single-cycle coin pulses (values 1/2/5)
//     i_cancel              : single-cycle refund request
//     i_change_ack          : change dispenser took o_change
//     i_sum                 : current credit from sum_register
//     o_sum_rst_n           : sum_register clear, active low, acts at next edge
//     o_sum_ld / o_sum_nxt  : sum_register load strobe and new credit
//     o_dispense            : one-cycle item release
//     o_change_valid/o_change : change handshake (o_change = 0 when not valid)
//     o_reject              : one-cycle coin return
//     o_busy                : controller not in S_COLLECT
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE = PRICE_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_nickel,
  input  logic             i_dime,
  input  logic             i_quarter,
  input  logic             i_cancel,
  input  logic             i_change_ack,
  input  logic [SUM_W-1:0] i_sum,
  output logic             o_sum_rst_n,
  output logic             o_sum_ld,
  output logic [SUM_W-1:0] o_sum_nxt,
  output logic             o_dispense,
  output logic             o_change_valid,
  output logic [SUM_W-1:0] o_change,
  output logic             o_reject,
  output logic             o_busy
);

  localparam logic [SUM_W:0] PRICE_X = (SUM_W+1)'(PRICE);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] change_q, change_d;

  logic             coin_valid;
  logic             coin_multi;
  logic [2:0]       coin_value;
  logic             coin_any;
  logic [SUM_W:0]   add;
  logic [SUM_W:0]   over;

  vending_coin_decode u_coin_decode (
    .i_nickel  (i_nickel),
    .i_dime    (i_dime),
    .i_quarter (i_quarter),
    .o_valid   (coin_valid),
    .o_multi   (coin_multi),
    .o_value   (coin_value)
  );

  assign coin_any = coin_valid | coin_multi;

  // One bit wider than the credit so a quarter on top of existing credit
  // cannot wrap before the price compare.
  assign add  = {1'b0, i_sum} + (SUM_W+1)'(coin_value);
  assign over = add - PRICE_X;

  always_comb begin
    state_d        = state_q;
    change_d       = change_q;
    o_sum_rst_n    = 1'b1;
    o_sum_ld       = 1'b0;
    o_sum_nxt      = i_sum;
    o_dispense     = 1'b0;
    o_change_valid = 1'b0;
    o_change       = '0;
    o_reject       = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        // A refund only happens with credit present; a cancel at zero credit
        // is a no-op and any accompanying coin is handled normally.
        if (i_cancel && (i_sum != '0)) begin
          change_d    = i_sum;
          o_sum_rst_n = 1'b0;
          o_reject    = coin_any;
          state_d     = S_CHANGE;
        end else if (coin_multi) begin
          o_reject = 1'b1;
        end else if (coin_valid) begin
          if (add < PRICE_X) begin
            o_sum_ld  = 1'b1;
            o_sum_nxt = add[SUM_W-1:0];
          end else begin
            // Register is cleared in S_DISPENSE, so no load here.
            change_d = over[SUM_W-1:0];
            state_d  = S_DISPENSE;
          end
        end
      end

      S_DISPENSE: begin
        o_dispense  = 1'b1;
        o_sum_rst_n = 1'b0;
        o_reject    = coin_any;
        state_d     = (change_q != '0) ? S_CHANGE : S_COLLECT;
      end

      S_CHANGE: begin
        o_change_valid = 1'b1;
        o_change       = change_q;
        o_reject       = coin_any;
        if (i_change_ack) begin
          change_d = '0;
          state_d  = S_COLLECT;
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase

    // Reset masks every output immediately and keeps the credit register
    // clearing on each edge while held.
    if (i_rst) begin
      o_sum_rst_n    = 1'b0;
      o_sum_ld       = 1'b0;
      o_sum_nxt      = '0;
      o_dispense     = 1'b0;
      o_change_valid = 1'b0;
      o_change       = '0;
      o_reject       = 1'b0;
    end
  end

  assign o_busy = (state_q != S_COLLECT) & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_COLLECT;
      change_q <= '0;
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
    end
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl
//   Directed bench for vending_ctrl with a behavioural sum_register alongside.
//   Inputs change 1 time unit after the rising edge; outputs are checked 1
//   more unit later, well clear of the next edge.
module tb_vending_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_nickel, i_dime, i_quarter, i_cancel, i_change_ack;
  logic [2:0] sum_q;
  logic       o_sum_rst_n, o_sum_ld, o_dispense, o_change_valid, o_reject, o_busy;
  logic [2:0] o_sum_nxt, o_change;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  // sum_register model: synchronous active-low clear, load strobe.
  initial sum_q = 3'd7;
  always @(posedge i_clk) begin
    if (!o_sum_rst_n)  sum_q <= 3'd0;
    else if (o_sum_ld) sum_q <= o_sum_nxt;
  end

  vending_ctrl #(.PRICE(4), .SUM_W(3)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_nickel       (i_nickel),
    .i_dime         (i_dime),
    .i_quarter      (i_quarter),
    .i_cancel       (i_cancel),
    .i_change_ack   (i_change_ack),
    .i_sum          (sum_q),
    .o_sum_rst_n    (o_sum_rst_n),
    .o_sum_ld       (o_sum_ld),
    .o_sum_nxt      (o_sum_nxt),
    .o_dispense     (o_dispense),
    .o_change_valid (o_change_valid),
    .o_change       (o_change),
    .o_reject       (o_reject),
    .o_busy         (o_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop all pulses.
  task automatic tick();
    @(posedge i_clk);
    #1;
    i_nickel = 0; i_dime = 0; i_quarter = 0; i_cancel = 0; i_change_ack = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    i_rst = 1;
    i_nickel = 0; i_dime = 0; i_quarter = 0; i_cancel = 0; i_change_ack = 0;

    // Reset held 3 cycles, a coin pulse present to show outputs stay masked
    for (int c = 0; c < 3; c++) begin
      #1;
      i_nickel = 1;
      settle();
      chk("rst_sum_rst_n", o_sum_rst_n, 0);
      chk("rst_ld", o_sum_ld, 0);
      chk("rst_reject", o_reject, 0);
      chk("rst_misc", {o_dispense, o_change_valid, o_busy, o_change}, 0);
      tick();
    end
    i_rst = 0;
    settle();
    chk("post_rst_sum", sum_q, 0);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_rst_n", o_sum_rst_n, 1);

    // Nickel, nickel, dime: exact price, no change
    i_nickel = 1; settle();
    chk("n1_ld", o_sum_ld, 1);
    chk("n1_nxt", o_sum_nxt, 1);
    tick();
    i_nickel = 1; settle();
    chk("n2_sum", sum_q, 1);
    chk("n2_ld", o_sum_ld, 1);
    chk("n2_nxt", o_sum_nxt, 2);
    tick();
    i_dime = 1; settle();
    chk("d3_sum", sum_q, 2);
    chk("d3_ld", o_sum_ld, 0);
    chk("d3_reject", o_reject, 0);
    tick();
    settle();
    chk("disp1_pulse", o_dispense, 1);
    chk("disp1_rst_n", o_sum_rst_n, 0);
    chk("disp1_busy", o_busy, 1);
    chk("disp1_cv", o_change_valid, 0);
    tick();
    settle();
    chk("after1_sum", sum_q, 0);
    chk("after1_cv", o_change_valid, 0);
    chk("after1_disp", o_dispense, 0);
    chk("after1_busy", o_busy, 0);

    // Dime, nickel, quarter: add = 8, change 4, ack after 3 valid cycles
    i_dime = 1; settle();
    chk("d_nxt", o_sum_nxt, 2);
    tick();
    i_nickel = 1; settle();
    chk("n_nxt", o_sum_nxt, 3);
    tick();
    i_quarter = 1; settle();
    chk("q_sum", sum_q, 3);
    chk("q_ld", o_sum_ld, 0);
    tick();
    settle();
    chk("disp2_pulse", o_dispense, 1);
    tick();
    settle();
    chk("chg_v1", o_change_valid, 1);
    chk("chg_c1", o_change, 4);
    chk("chg_sum", sum_q, 0);
    tick();
    i_dime = 1; settle();
    chk("chg_rej", o_reject, 1);
    chk("chg_rej_ld", o_sum_ld, 0);
    chk("chg_v2", o_change_valid, 1);
    chk("chg_c2", o_change, 4);
    tick();
    i_change_ack = 1; settle();
    chk("chg_rej_sum", sum_q, 0);
    chk("chg_v3", o_change_valid, 1);
    chk("chg_c3", o_change, 4);
    tick();
    settle();
    chk("ack_cv", o_change_valid, 0);
    chk("ack_c", o_change, 0);
    chk("ack_busy", o_busy, 0);

    // Cancel with credit 2, acked in the first valid cycle
    i_nickel = 1; tick();
    i_nickel = 1; tick();
    i_cancel = 1; settle();
    chk("can_rst_n", o_sum_rst_n, 0);
    chk("can_rej", o_reject, 0);
    tick();
    i_change_ack = 1; settle();
    chk("can_cv", o_change_valid, 1);
    chk("can_c", o_change, 2);
    chk("can_sum", sum_q, 0);
    tick();
    settle();
    chk("can_done", o_busy, 0);

    // Cancel at zero credit does nothing
    i_cancel = 1; settle();
    chk("can0_rst_n", o_sum_rst_n, 1);
    chk("can0_rej", o_reject, 0);
    tick();
    settle();
    chk("can0_busy", o_busy, 0);
    chk("can0_cv", o_change_valid, 0);

    // Ack outside S_CHANGE is ignored; nickel + dime together is rejected
    i_change_ack = 1; i_nickel = 1; i_dime = 1; settle();
    chk("multi_rej", o_reject, 1);
    chk("multi_ld", o_sum_ld, 0);
    tick();
    settle();
    chk("multi_sum", sum_q, 0);
    chk("multi_busy", o_busy, 0);

    // Coin + cancel with credit: refund wins, coin rejected
    i_dime = 1; tick();
    i_cancel = 1; i_nickel = 1; settle();
    chk("cc_rej", o_reject, 1);
    chk("cc_ld", o_sum_ld, 0);
    chk("cc_rst_n", o_sum_rst_n, 0);
    tick();
    settle();
    chk("cc_c", o_change, 2);
    i_change_ack = 1;
    tick();

    // Quarter from zero (change 1), then reset while change is pending
    i_quarter = 1; tick();
    tick();
    settle();
    chk("rc_cv", o_change_valid, 1);
    chk("rc_c", o_change, 1);
    i_rst = 1; settle();
    chk("rc_cv_drop", o_change_valid, 0);
    chk("rc_c_drop", o_change, 0);
    chk("rc_busy", o_busy, 0);
    chk("rc_rst_n", o_sum_rst_n, 0);
    tick();
    i_rst = 0; settle();
    chk("rc_after_cv", o_change_valid, 0);
    chk("rc_after_busy", o_busy, 0);
    chk("rc_after_sum", sum_q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
- FSM controller that sequences the vending machine's 3-bit credit register (sum_register).
- Accepts coin pulses and updates the register's credit as (current + coin value). When credit reaches PRICE it dispenses the item, clears the register and returns change over a valid/ack handshake.
- Sits between the coin-acceptor front end and sum_register. It reads the register output and drives its load and active-low clear inputs.

Parameters:
- PRICE, 4, item price in 5-cent units (legal range 1..7).
- SUM_W, 3, credit/change width; must match sum_register.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_nickel  in  1  single-cycle coin pulse, value 1.
- i_dime  in  1  single-cycle coin pulse, value 2.
- i_quarter  in  1  single-cycle coin pulse, value 5.
- i_cancel  in  1  single-cycle refund request.
- i_change_ack  in  1  change dispenser accepted o_change.
- i_sum  in  SUM_W  current credit, from sum_register o_sum.
- o_sum_rst_n  out  1  to sum_register i_sum_rst; 0 = clear at next edge.
- o_sum_ld  out  1  to sum_register i_sum_ld.
- o_sum_nxt  out  SUM_W  to sum_register i_sum.
- o_dispense  out  1  one-cycle item release pulse.
- o_change_valid  out  1  change amount valid.
- o_change  out  SUM_W  change in 5-cent units.
- o_reject  out  1  one-cycle coin-return pulse.
- o_busy  out  1  high in any state other than S_COLLECT.

Behaviour:
- States: S_COLLECT, S_DISPENSE, S_CHANGE. State and change_q are flops, asynchronously reset by i_rst.
- While i_rst is high:
  - State is S_COLLECT and change_q = 0.
  - o_sum_rst_n = 0, driven combinationally from i_rst, so the register clears on every edge during reset.
  - All other outputs = 0.
- Coin decode:
  - Exactly one coin bit high gives a valid coin with value v.
  - More than one coin bit high in the same cycle means o_reject = 1 that cycle, no load, no state change.
- S_COLLECT:
  - add = i_sum + v, computed 4 bits wide with no truncation.
  - Valid coin with add < PRICE: o_sum_ld = 1 and o_sum_nxt = add[2:0]. The new credit appears on i_sum next cycle, so back-to-back coins on consecutive cycles must accumulate correctly.
  - Valid coin with add >= PRICE: change_q <= add - PRICE (max 4), no load, next state S_DISPENSE.
  - i_cancel with i_sum != 0: change_q <= i_sum, o_sum_rst_n = 0, next state S_CHANGE.
  - i_cancel with i_sum == 0: ignored.
  - i_cancel together with a coin: cancel wins and the coin is rejected (o_reject = 1).
- S_DISPENSE (exactly 1 cycle):
  - o_dispense = 1 and o_sum_rst_n = 0.
  - Next state S_CHANGE if change_q != 0, else S_COLLECT.
- S_CHANGE:
  - o_change_valid = 1 and o_change = change_q, both held stable until i_change_ack.
  - Ack is sampled at the edge. On ack: next state S_COLLECT, change_q <= 0.
  - Ack in the same cycle valid first rises is accepted (1-cycle transfer).
  - i_change_ack outside S_CHANGE: ignored.
- Coin in S_DISPENSE or S_CHANGE: o_reject = 1, credit untouched.
- i_cancel in S_DISPENSE or S_CHANGE: ignored.
- Default output values (whenever not asserted above): o_sum_ld = 0, o_sum_rst_n = 1, o_sum_nxt = i_sum, o_dispense = 0, o_reject = 0.
- o_change = 0 whenever o_change_valid = 0.
- All outputs except o_sum_rst_n during reset are combinational from state and inputs (Mealy).
- Asynchronous reset mid-transaction: outputs drop immediately, pending change is lost, credit is cleared.

Decomposition:
- Package vending_pkg:
  - state_e enum (S_COLLECT, S_DISPENSE, S_CHANGE).
  - Coin value constants COIN_NICKEL = 1, COIN_DIME = 2, COIN_QUARTER = 5.
  - Default PRICE.
- Sub-module vending_coin_decode (combinational): coin bits in, {valid, multi, value[2:0]} out.
- sum_register is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Assert i_rst for 3 cycles -> o_sum_rst_n = 0 throughout, all other outputs 0. After release: i_sum = 0, o_busy = 0.
- Nickel, nickel, dime on consecutive cycles (PRICE = 4):
  - First two cycles load 1 then 2.
  - Dime gives add = 4: o_dispense pulses, o_sum_rst_n = 0, i_sum = 0 next cycle, no o_change_valid.
- Dime then nickel (sum = 3), then quarter (add = 8):
  - Dispense pulse, then o_change_valid with o_change = 4.
  - Held 3 cycles until i_change_ack, then back to S_COLLECT.
- Cancel:
  - Nickel, nickel, then i_cancel -> o_change = 2, register cleared.
  - i_cancel at sum = 0 -> no response.
- Rejects:
  - Dime during S_CHANGE -> o_reject pulse, change_q and i_sum unchanged.
  - Nickel + dime in the same cycle in S_COLLECT -> o_reject, no load.
  - Coin + cancel in the same cycle -> refund and reject.
- Assert i_rst mid-S_CHANGE (valid high, no ack) -> o_change_valid drops in the same cycle, state S_COLLECT, credit 0 after release.
